// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package seg_scan_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 8;

    // All cathodes off (active-low); slice down to the configured digit count.
    localparam logic [MAX_DIGITS-1:0] CAT_OFF = '1;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Codes 10..15 are not displayable digits and force the decoder dark.
    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Slot prescaler: counts 0..DIV-1 while enabled, holds otherwise.
// Exposes the next-state count so the parent can register outputs in step with it.
module seg_scan_tick #(
    parameter int unsigned DIV = 1000,
    parameter int unsigned PW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [PW-1:0] presc,
    output logic          slot_wrap
);

    logic [PW-1:0] presc_q;

    assign slot_wrap = en && (presc_q == PW'(DIV - 1));

    // Next prescaler value: wrap at end of slot, hold while disabled.
    always_comb begin
        presc = presc_q;
        if (slot_wrap) begin
            presc = '0;
        end else if (en) begin
            presc = presc_q + PW'(1);
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan controller.
// Data is double-buffered (pend -> shadow) and swapped only at frame wrap to avoid tearing.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]           dp_in,
    output logic [DIGIT_W-1:0]          bcd_out,
    output logic                        dp_out,
    output logic                        blank,
    output logic [DIGITS-1:0]           cat,
    output logic                        frame_done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned BW = DIGIT_W * DIGITS;

    logic [PW-1:0]       presc_next;
    logic                slot_wrap;
    logic                frame_wrap;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       shadow_q, shadow_d, pend_q, pend_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
    logic                pend_v_q, pend_v_d;
    logic [DIGIT_W-1:0]  digit;
    logic                digit_dp;
    logic                dark;
    logic                suppress;
    logic [DIGITS-1:0]   cat_d;

    seg_scan_tick #(
        .DIV (DIV),
        .PW  (PW)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .presc     (presc_next),
        .slot_wrap (slot_wrap)
    );

    // Digit index advances once per slot; wrapping past the last digit ends the frame.
    always_comb begin
        idx_d      = idx_q;
        frame_wrap = 1'b0;
        if (slot_wrap) begin
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d      = '0;
                frame_wrap = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Pending/shadow buffers: a load on the wrap edge bypasses pend straight into shadow.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_v_d    = pend_v_q;
        if (frame_wrap) begin
            pend_v_d = 1'b0;
            if (load) begin
                shadow_d    = bcd_in;
                shadow_dp_d = dp_in;
            end else if (pend_v_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
            end
        end else if (load) begin
            pend_d    = bcd_in;
            pend_dp_d = dp_in;
            pend_v_d  = 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] lz;

    // Leading-zero run from the MSD down; digit 0 is never suppressed.
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run   = run && (shadow_d[i*DIGIT_W +: DIGIT_W] == '0) && !shadow_dp_d[i];
            lz[i] = run;
        end
    end
`endif

    // Output decode from next-state counters so registered outputs track the counter edge.
    always_comb begin
        digit    = '0;
        digit_dp = 1'b0;
        suppress = 1'b0;
        dark     = !en || (32'(presc_next) < BLANK_CYC);
        cat_d    = CAT_OFF[DIGITS-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                digit    = shadow_d[i*DIGIT_W +: DIGIT_W];
                digit_dp = shadow_dp_d[i];
`ifdef SEG_LZB_EN
                suppress = lz[i];
`endif
                cat_d[i] = dark;
            end
        end
    end

    // Counter and buffer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_v_q    <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_v_q    <= pend_v_d;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cat        <= CAT_OFF[DIGITS-1:0];
            bcd_out    <= '0;
            dp_out     <= 1'b0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cat        <= cat_d;
            bcd_out    <= digit;
            dp_out     <= digit_dp;
            blank      <= dark || !bcd_valid(digit) || suppress;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIGITS=4, DIV=8, BLANK_CYC=2).
// Honours SEG_LZB_EN in its reference model when the macro is defined.
module tb_seg_scan_mux;

    localparam int DIGITS    = 4;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  bcd_out;
    logic        dp_out, blank, frame_done;
    logic [3:0]  cat;

    seg_scan_mux #(
        .DIGITS    (DIGITS),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .blank      (blank),
        .cat        (cat),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    endtask

    // Reference model: position within the frame as one flat enabled-cycle count.
    int m_pos;
    int m_sh[DIGITS];
    int m_shdp[DIGITS];
    int m_pd[DIGITS];
    int m_pddp[DIGITS];
    bit m_pv;
    int e_cat, e_blank, e_bcd, e_dp, e_fd;
    bit m_valid = 1'b0;

    function automatic bit lzb(input int ix);
        bit on = 1'b0;
`ifdef SEG_LZB_EN
        on = 1'b1;
`endif
        if (!on || ix == 0) return 1'b0;
        for (int j = ix; j < DIGITS; j++)
            if (m_sh[j] != 0 || m_shdp[j] != 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit wrap;
        bit dark;
        int pr, ix;
        if (rst) begin
            m_pos = 0;
            m_pv  = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                m_sh[i] = 0; m_shdp[i] = 0; m_pd[i] = 0; m_pddp[i] = 0;
            end
            e_cat = 15; e_blank = 1; e_bcd = 0; e_dp = 0; e_fd = 0;
        end else begin
            wrap = en && (m_pos == FRAME - 1);
            if (en) m_pos = (m_pos + 1) % FRAME;
            if (wrap) begin
                if (load) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        m_sh[i] = int'(bcd_in[4*i +: 4]); m_shdp[i] = int'(dp_in[i]);
                    end
                end else if (m_pv) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        m_sh[i] = m_pd[i]; m_shdp[i] = m_pddp[i];
                    end
                end
                m_pv = 1'b0;
            end else if (load) begin
                for (int i = 0; i < DIGITS; i++) begin
                    m_pd[i] = int'(bcd_in[4*i +: 4]); m_pddp[i] = int'(dp_in[i]);
                end
                m_pv = 1'b1;
            end
            pr      = m_pos % DIV;
            ix      = m_pos / DIV;
            dark    = !en || (pr < BLANK_CYC);
            e_bcd   = m_sh[ix];
            e_dp    = m_shdp[ix];
            e_cat   = dark ? 15 : (15 & ~(1 << ix));
            e_blank = (dark || m_sh[ix] > 9 || lzb(ix)) ? 1 : 0;
            e_fd    = wrap ? 1 : 0;
        end
        m_valid = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cat",        int'(cat),        e_cat);
            check("blank",      int'(blank),      e_blank);
            check("bcd_out",    int'(bcd_out),    e_bcd);
            check("dp_out",     int'(dp_out),     e_dp);
            check("frame_done", int'(frame_done), e_fd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v; dp_in = d; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 100);
        check("frame_done_wait", int'(frame_done === 1'b1), 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
        step(3);
        check("rst_cat", int'(cat), 4'b1111);
        check("rst_blank", int'(blank), 1);
        check("rst_bcd", int'(bcd_out), 0);
        check("rst_fd", int'(frame_done), 0);
        rst = 1'b0;
        step(1);
        check("post_rst_cat", int'(cat), 4'b1111);
        check("post_rst_fd", int'(frame_done), 0);

        // First frame: 1234 appears only after the wrap, slot order LSD first.
        en = 1'b1;
        load_val(16'h1234, 4'b0000);
        wait_frame();
        check("slot0_dead_cat", int'(cat), 4'b1111);
        check("slot0_dead_blank", int'(blank), 1);
        step(2);
        check("slot0_cat", int'(cat), 4'b1110);
        check("slot0_blank", int'(blank), 0);
        check("slot0_bcd", int'(bcd_out), 4);
        step(8);
        check("slot1_cat", int'(cat), 4'b1101);
        check("slot1_bcd", int'(bcd_out), 3);
        step(8);
        check("slot2_cat", int'(cat), 4'b1011);
        check("slot2_bcd", int'(bcd_out), 2);
        step(8);
        check("slot3_cat", int'(cat), 4'b0111);
        check("slot3_bcd", int'(bcd_out), 1);
        step(6);
        check("frame_period", int'(frame_done), 1);

        // Mid-frame load, then last-wins overwrite inside one frame.
        step(5);
        load_val(16'h5678, 4'b0000);
        wait_frame();
        step(10);
        load_val(16'h9999, 4'b0000);
        step(3);
        load_val(16'h0042, 4'b0000);
        wait_frame();
        step(2);
        check("lastwin_slot0", int'(bcd_out), 2);
        step(8);
        check("lastwin_slot1", int'(bcd_out), 4);

        // Load exactly on the wrap edge bypasses into slot 0 of the new frame.
        wait_frame();
        step(31);
        bcd_in = 16'h7654; dp_in = 4'b0001; load = 1'b1;
        step(1);
        load = 1'b0;
        check("bypass_fd", int'(frame_done), 1);
        step(2);
        check("bypass_bcd", int'(bcd_out), 4);
        check("bypass_dp", int'(dp_out), 1);
        step(30);
        check("bypass_next_fd", int'(frame_done), 1);
        step(2);
        check("bypass_next_bcd", int'(bcd_out), 4);

        // Invalid code in digit 2 and an enable gap mid-slot.
        load_val(16'h1A00, 4'b0000);
        wait_frame();
        wait_frame();
        step(19);
        check("hex_cat", int'(cat), 4'b1011);
        check("hex_blank", int'(blank), 1);
        check("hex_bcd", int'(bcd_out), 4'hA);
        en = 1'b0;
        step(5);
        check("en0_cat", int'(cat), 4'b1111);
        check("en0_blank", int'(blank), 1);
        en = 1'b1;
        step(1);
        check("resume_cat", int'(cat), 4'b1011);
        step(12);
        check("resume_fd", int'(frame_done), 1);

        // Leading-zero patterns (blanking only when SEG_LZB_EN is defined).
        load_val(16'h0040, 4'b0000);
        wait_frame();
        step(FRAME);
        load_val(16'h0000, 4'b0000);
        step(FRAME);
        step(FRAME);
        load_val(16'h0000, 4'b1000);
        step(FRAME);
        step(FRAME);

        // Randomised traffic with occasional resets and enable gaps.
        for (int c = 0; c < 2000; c++) begin
            rst    = ($urandom % 400) == 0;
            en     = ($urandom % 10) != 0;
            load   = ($urandom % 25) == 0;
            bcd_in = 16'($urandom);
            if (($urandom % 3) == 0) bcd_in = bcd_in & 16'h00FF;
            dp_in  = (($urandom % 2) == 0) ? 4'b0000 : 4'($urandom);
            step(1);
        end
        rst = 1'b0; load = 1'b0; en = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
